axi_master_rr_arbiter: RTL and testbench
========================================

# axi_master_rr_arbiter

Parametrised master-side arbiter for the AXI4 interconnect. It supports any master count, grants the shared write-address and read-address channels round-robin, and holds each grant through backpressure. A write-order queue lets several write addresses be accepted before their data, and W bursts are routed strictly in AW acceptance order. It sits beside the slave-side arbiter and drives the master mux selects of the crossbar.

## Interface
- M_COUNT, 4 — number of masters, 2..16, need not be a power of two
- M_ID, 2 — master-local ID width; bus ID = {master index, local ID}
- WQ_DEPTH, 4 — write-order queue depth, power of two, ≥2
- Derived: SEL_W = max(1, $clog2(M_COUNT)); CNT_W = $clog2(WQ_DEPTH+1)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m_aw_valid  in  M_COUNT  per-master AWVALID
- m_ar_valid  in  M_COUNT  per-master ARVALID
- bus_aw_valid / bus_aw_ready  in  1  muxed AW handshake
- bus_w_valid / bus_w_ready / bus_w_last  in  1  muxed W handshake and WLAST
- bus_ar_valid / bus_ar_ready  in  1  muxed AR handshake
- bus_b_id  in  M_ID+SEL_W  BID from slave side
- bus_r_id  in  M_ID+SEL_W  RID from slave side
- aw_sel  out  SEL_W  AW master select
- aw_gnt  out  1  AW grant valid; crossbar ANDs it into bus AWVALID and master AWREADY
- w_sel  out  SEL_W  W master select (queue head)
- w_gnt  out  1  W route valid; crossbar gates WVALID/WREADY with it
- ar_sel  out  SEL_W  AR master select
- ar_gnt  out  1  AR grant valid
- b_sel  out  SEL_W  B route = bus_b_id[M_ID +: SEL_W]
- r_sel  out  SEL_W  R route = bus_r_id[M_ID +: SEL_W]
- wq_full  out  1  write-order queue full

## Operation
- AW arbiter:
  - Unlocked: the grant goes to the first requester in the search order. aw_gnt = |m_aw_valid && !wq_full.
  - Lock is set when bus_aw_valid && !bus_aw_ready. While locked, aw_sel is held at the registered grant and aw_gnt=1.
  - Lock clears on the handshake.
- AR arbiter: same structure with its own lock and pointer. ar_gnt = |m_ar_valid. There is no queue gating.
- Round-robin pointer (one per channel):
  - Holds the index of the last master granted.
  - Search order is pointer+1 … M_COUNT-1, 0 … pointer.
  - Updates only on a handshake (bus_x_valid && bus_x_ready).
- Indices ≥ M_COUNT are never selected.
- Write-order queue:
  - Circular FIFO of SEL_W-bit entries with read/write pointers and an occupancy count.
  - Push aw_sel on the AW handshake; pop on bus_w_valid && bus_w_ready && bus_w_last.
  - w_sel = head entry; w_gnt = count≠0.
- Queue boundary conditions:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: aw_gnt=0, so no push occurs.
  - Empty: w_gnt=0, so no pop occurs and there is no W bypass.
  - Pointers wrap modulo WQ_DEPTH.
- B/R routing is purely combinational from the ID; interleaving is permitted.

## Timing
- Reset values:
  - aw_sel, w_sel, ar_sel = 0; aw_gnt, w_gnt, ar_gnt = 0 with no requests.
  - b_sel, r_sel follow the IDs combinationally.
  - wq_full = 0; queue empty; both RR pointers = M_COUNT-1, so master 0 has first priority.
- Grant latency: 0 cycles. aw_sel/ar_sel are combinational from requests plus registered lock and pointer.
- W route: available from the cycle after the AW handshake (1-cycle queue latency).
- A grant never changes while its channel is locked, even if the granted master deasserts valid (AXI forbids this).
- Reset mid-burst flushes the queue and locks. The master and slave sides must be reset together.

## Configuration
- AXI_ARB_RR_EN defined: round-robin arbitration as above.
- AXI_ARB_RR_EN undefined:
  - Fixed priority, lowest index wins.
  - RR pointers are removed and the search order is always 0 … M_COUNT-1.
  - Lock and queue behaviour is unchanged.

## Test plan
- M_COUNT=3; masters 0,1,2 hold m_ar_valid with bus_ar_ready=1 → with RR_EN, ar_sel sequence 0,1,2,0. Without RR_EN, 0,0,0.
- Master 1 AW with bus_aw_ready=0 for 3 cycles while master 0 raises valid → aw_sel stays 1 until the handshake, then switches to 0.
- WQ_DEPTH=4; accept 4 AWs (masters 2,0,1,3) with W stalled → wq_full=1 and aw_gnt=0. W bursts then complete in order 2,0,1,3.
- Same-cycle AW handshake and W last with count=2 → count stays 2; w_sel advances to the next entry.
- bus_r_id={2'd3,2'd1}, bus_b_id={2'd2,2'd0} → r_sel=3, b_sel=2 in the same cycle.
- Assert rstn low mid-burst with count=3 → after release, w_gnt=0, wq_full=0, aw_sel=0; next grant goes to master 0.

Source files
------------

// File: rtl/axi_master_rr_arbiter.sv
// AXI4 master-side arbiter: locked AW/AR grants plus a write-order queue that routes W in AW order.
// Define AXI_ARB_RR_EN for round-robin search; otherwise fixed priority, lowest index wins.

module axi_master_rr_chan #(
    parameter int M_COUNT = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [M_COUNT-1:0] req_i,
    input  logic               allow_i,
    input  logic               bus_valid_i,
    input  logic               bus_ready_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               gnt_o
);
    typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(M_COUNT - 1);

    arb_state_t       state_q;
    logic [SEL_W-1:0] lock_sel_q;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic             hs;

    assign hs = bus_valid_i && bus_ready_i && gnt_o;

`ifdef AXI_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   ptr_q <= LAST_IDX;
        else if (hs) ptr_q <= sel_o;
    end

    assign base = ptr_q;
`else
    assign base = LAST_IDX;
`endif

    // Walk base+1 .. M_COUNT-1, 0 .. base; the wrap at LAST_IDX keeps unused indices out of reach.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = base;
        for (int i = 0; i < M_COUNT; i++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + SEL_W'(1);
            if (!found && req_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_OPEN;
            lock_sel_q <= '0;
        end else begin
            case (state_q)
                ARB_OPEN:
                    if (bus_valid_i && !bus_ready_i && gnt_o) begin
                        state_q    <= ARB_LOCKED;
                        lock_sel_q <= pick;
                    end
                ARB_LOCKED:
                    if (hs) state_q <= ARB_OPEN;
                default: state_q <= ARB_OPEN;
            endcase
        end
    end

    assign sel_o = (state_q == ARB_LOCKED) ? lock_sel_q : pick;
    assign gnt_o = (state_q == ARB_LOCKED) || ((|req_i) && allow_i);
endmodule

module axi_master_rr_arbiter #(
    parameter  int M_COUNT  = 4,
    parameter  int M_ID     = 2,
    parameter  int WQ_DEPTH = 4,
    localparam int SEL_W    = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
    localparam int CNT_W    = $clog2(WQ_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [M_COUNT-1:0]    m_aw_valid,
    input  logic [M_COUNT-1:0]    m_ar_valid,
    input  logic                  bus_aw_valid,
    input  logic                  bus_aw_ready,
    input  logic                  bus_w_valid,
    input  logic                  bus_w_ready,
    input  logic                  bus_w_last,
    input  logic                  bus_ar_valid,
    input  logic                  bus_ar_ready,
    input  logic [M_ID+SEL_W-1:0] bus_b_id,
    input  logic [M_ID+SEL_W-1:0] bus_r_id,
    output logic [SEL_W-1:0]      aw_sel,
    output logic                  aw_gnt,
    output logic [SEL_W-1:0]      w_sel,
    output logic                  w_gnt,
    output logic [SEL_W-1:0]      ar_sel,
    output logic                  ar_gnt,
    output logic [SEL_W-1:0]      b_sel,
    output logic [SEL_W-1:0]      r_sel,
    output logic                  wq_full
);
    localparam int PTR_W = $clog2(WQ_DEPTH);

    logic [SEL_W-1:0] wq_mem [WQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    axi_master_rr_chan #(.M_COUNT(M_COUNT), .SEL_W(SEL_W)) u_aw_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (m_aw_valid),
        .allow_i     (!wq_full),
        .bus_valid_i (bus_aw_valid),
        .bus_ready_i (bus_aw_ready),
        .sel_o       (aw_sel),
        .gnt_o       (aw_gnt)
    );

    axi_master_rr_chan #(.M_COUNT(M_COUNT), .SEL_W(SEL_W)) u_ar_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (m_ar_valid),
        .allow_i     (1'b1),
        .bus_valid_i (bus_ar_valid),
        .bus_ready_i (bus_ar_ready),
        .sel_o       (ar_sel),
        .gnt_o       (ar_gnt)
    );

    assign push = bus_aw_valid && bus_aw_ready && aw_gnt;
    assign pop  = bus_w_valid && bus_w_ready && bus_w_last && w_gnt;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: queue storage is not reset; w_sel masks it while the count is zero.
    always_ff @(posedge clk) begin
        if (push) wq_mem[wr_ptr_q] <= aw_sel;
    end

    assign w_gnt   = (cnt_q != '0);
    assign w_sel   = w_gnt ? wq_mem[rd_ptr_q] : '0;
    assign wq_full = (cnt_q == CNT_W'(WQ_DEPTH));

    assign b_sel = SEL_W'(bus_b_id >> M_ID);
    assign r_sel = SEL_W'(bus_r_id >> M_ID);
endmodule

// File: tb/tb_axi_master_rr_arbiter.sv
// Bench for axi_master_rr_arbiter: a 4-master/4-deep instance for AW/W/AR/B/R behaviour and a
// 3-master instance for the non-power-of-two AR rotation; W order is checked against a scoreboard.

module tb_axi_master_rr_arbiter;
`ifdef AXI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] m_aw_valid, m_ar_valid;
    logic       bus_aw_valid, bus_aw_ready;
    logic       bus_w_valid, bus_w_ready, bus_w_last;
    logic       bus_ar_valid, bus_ar_ready;
    logic [3:0] bus_b_id, bus_r_id;
    logic [1:0] aw_sel, w_sel, ar_sel, b_sel, r_sel;
    logic       aw_gnt, w_gnt, ar_gnt, wq_full;
    logic       w_src_valid, w_src_last;

    logic [2:0] m3_ar_valid;
    logic       bus3_ar_valid, bus3_ar_ready;
    logic [1:0] aw3_sel, w3_sel, ar3_sel, b3_sel, r3_sel;
    logic       aw3_gnt, w3_gnt, ar3_gnt, wq3_full;

    int         checks   = 0;
    int         failures = 0;
    int         exp_q[$];

    always #5 clk = ~clk;

    // Crossbar-side muxing: the bus valids are the granted master's valid.
    assign bus_aw_valid  = aw_gnt & m_aw_valid[aw_sel];
    assign bus_ar_valid  = ar_gnt & m_ar_valid[ar_sel];
    assign bus_w_valid   = w_gnt & w_src_valid;
    assign bus_w_last    = w_src_last;
    assign bus3_ar_valid = ar3_gnt & m3_ar_valid[ar3_sel];

    axi_master_rr_arbiter #(.M_COUNT(4), .M_ID(2), .WQ_DEPTH(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .m_aw_valid(m_aw_valid), .m_ar_valid(m_ar_valid),
        .bus_aw_valid(bus_aw_valid), .bus_aw_ready(bus_aw_ready),
        .bus_w_valid(bus_w_valid), .bus_w_ready(bus_w_ready), .bus_w_last(bus_w_last),
        .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready),
        .bus_b_id(bus_b_id), .bus_r_id(bus_r_id),
        .aw_sel(aw_sel), .aw_gnt(aw_gnt), .w_sel(w_sel), .w_gnt(w_gnt),
        .ar_sel(ar_sel), .ar_gnt(ar_gnt), .b_sel(b_sel), .r_sel(r_sel),
        .wq_full(wq_full)
    );

    axi_master_rr_arbiter #(.M_COUNT(3), .M_ID(2), .WQ_DEPTH(4)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .m_aw_valid(3'b000), .m_ar_valid(m3_ar_valid),
        .bus_aw_valid(1'b0), .bus_aw_ready(1'b0),
        .bus_w_valid(1'b0), .bus_w_ready(1'b0), .bus_w_last(1'b0),
        .bus_ar_valid(bus3_ar_valid), .bus_ar_ready(bus3_ar_ready),
        .bus_b_id(4'h0), .bus_r_id(4'h0),
        .aw_sel(aw3_sel), .aw_gnt(aw3_gnt), .w_sel(w3_sel), .w_gnt(w3_gnt),
        .ar_sel(ar3_sel), .ar_gnt(ar3_gnt), .b_sel(b3_sel), .r_sel(r3_sel),
        .wq_full(wq3_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_accept(input int m);
        m_aw_valid   = 4'(1 << m);
        bus_aw_ready = 1'b1;
        #1;
        check("aw_accept_sel", 32'(aw_sel), 32'(m));
        check("aw_accept_gnt", 32'(aw_gnt), 1);
        exp_q.push_back(m);
        tick();
        m_aw_valid = 4'b0000;
    endtask

    task automatic w_burst(input int beats);
        int exp;
        for (int b = 0; b < beats; b++) begin
            w_src_valid = 1'b1;
            w_src_last  = (b == beats - 1);
            bus_w_ready = 1'b1;
            #1;
            check("w_gnt_in_burst", 32'(w_gnt), 1);
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp = w_src_last ? exp_q.pop_front() : exp_q[0];
                check("w_order", 32'(w_sel), 32'(exp));
            end
            tick();
        end
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
    endtask

    initial begin
        rstn         = 1'b0;
        m_aw_valid   = '0;
        m_ar_valid   = '0;
        bus_aw_ready = 1'b0;
        bus_ar_ready = 1'b0;
        bus_w_ready  = 1'b0;
        w_src_valid  = 1'b0;
        w_src_last   = 1'b0;
        m3_ar_valid  = '0;
        bus3_ar_ready = 1'b0;
        bus_b_id     = {2'd2, 2'd0};
        bus_r_id     = {2'd3, 2'd1};
        repeat (2) tick();

        check("rst_aw_sel", 32'(aw_sel), 0);
        check("rst_aw_gnt", 32'(aw_gnt), 0);
        check("rst_w_sel", 32'(w_sel), 0);
        check("rst_w_gnt", 32'(w_gnt), 0);
        check("rst_ar_sel", 32'(ar_sel), 0);
        check("rst_ar_gnt", 32'(ar_gnt), 0);
        check("rst_wq_full", 32'(wq_full), 0);
        check("rst_b_sel", 32'(b_sel), 2);
        check("rst_r_sel", 32'(r_sel), 3);
        rstn = 1'b1;
        tick();

        bus_b_id = {2'd1, 2'd3};
        bus_r_id = {2'd0, 2'd2};
        #1;
        check("b_sel_comb", 32'(b_sel), 1);
        check("r_sel_comb", 32'(r_sel), 0);

        // AR rotation with masters 0..2 requesting, on both the 4- and 3-master instances.
        m_ar_valid    = 4'b0111;
        bus_ar_ready  = 1'b1;
        m3_ar_valid   = 3'b111;
        bus3_ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("ar_rot4", 32'(ar_sel), RR ? 32'(k % 3) : 0);
            check("ar_rot3", 32'(ar3_sel), RR ? 32'(k % 3) : 0);
            check("ar_gnt_rot", 32'(ar_gnt), 1);
            tick();
        end
        m_ar_valid  = '0;
        m3_ar_valid = '0;
        #1;
        check("ar_gnt_idle", 32'(ar_gnt), 0);

        // AW lock: master 1 stalled three cycles while master 0 joins.
        m_aw_valid   = 4'b0010;
        bus_aw_ready = 1'b0;
        #1;
        check("lock_sel0", 32'(aw_sel), 1);
        tick();
        m_aw_valid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lock_sel_held", 32'(aw_sel), 1);
            check("lock_gnt_held", 32'(aw_gnt), 1);
            tick();
        end
        bus_aw_ready = 1'b1;
        #1;
        check("lock_sel_hs", 32'(aw_sel), 1);
        check("w_gnt_before_push", 32'(w_gnt), 0);
        exp_q.push_back(1);
        tick();
        m_aw_valid = 4'b0001;
        #1;
        check("unlock_sel", 32'(aw_sel), 0);
        check("w_gnt_after_push", 32'(w_gnt), 1);
        check("w_sel_after_push", 32'(w_sel), 1);
        exp_q.push_back(0);
        tick();

        // Simultaneous push (master 3) and W last with two entries queued.
        m_aw_valid  = 4'b1000;
        w_src_valid = 1'b1;
        w_src_last  = 1'b1;
        bus_w_ready = 1'b1;
        #1;
        check("simul_w_sel", 32'(w_sel), 32'(exp_q.pop_front()));
        exp_q.push_back(3);
        tick();
        m_aw_valid  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        #1;
        check("simul_w_gnt", 32'(w_gnt), 1);
        check("simul_w_adv", 32'(w_sel), 0);
        check("simul_not_full", 32'(wq_full), 0);
        w_burst(2);
        w_burst(1);
        #1;
        check("drain_w_gnt", 32'(w_gnt), 0);

        // Fill the queue with W stalled, then drain in acceptance order.
        aw_accept(2);
        aw_accept(0);
        aw_accept(1);
        aw_accept(3);
        #1;
        check("full_flag", 32'(wq_full), 1);
        m_aw_valid = 4'b1111;
        m_ar_valid = 4'b0100;
        #1;
        check("full_aw_gnt", 32'(aw_gnt), 0);
        check("full_ar_gnt", 32'(ar_gnt), 1);
        check("full_ar_sel", 32'(ar_sel), 2);
        tick();
        m_aw_valid = '0;
        m_ar_valid = '0;
        #1;
        check("full_no_push", 32'(wq_full), 1);
        w_burst(1);
        check("unfull_after_pop", 32'(wq_full), 0);
        repeat (3) w_burst(1);
        check("fill_drained", 32'(w_gnt), 0);

        // AW rotation with all four requesting; last grant was master 3.
        m_aw_valid   = 4'b1111;
        bus_aw_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("aw_rot", 32'(aw_sel), RR ? 32'(k) : 0);
            exp_q.push_back(RR ? k : 0);
            tick();
        end
        m_aw_valid = '0;

        // Reset mid-burst with three entries queued.
        w_src_valid = 1'b1;
        w_src_last  = 1'b0;
        bus_w_ready = 1'b1;
        #1;
        rstn = 1'b0;
        tick();
        #2;
        rstn        = 1'b1;
        w_src_valid = 1'b0;
        exp_q.delete();
        #1;
        check("post_rst_w_gnt", 32'(w_gnt), 0);
        check("post_rst_full", 32'(wq_full), 0);
        check("post_rst_aw_sel", 32'(aw_sel), 0);
        check("post_rst_aw_gnt", 32'(aw_gnt), 0);
        m_aw_valid = 4'b1111;
        #1;
        check("post_rst_first", 32'(aw_sel), 0);
        exp_q.push_back(0);
        tick();
        m_aw_valid = '0;
        w_burst(1);
        check("final_w_gnt", 32'(w_gnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
